// File: rtl/led_pkg.sv
// led_pkg: shared definitions for the LED output stages.
//   PWM_BITS_DEFAULT : default duty/level resolution
//   LEVEL_MAX        : full-on level for the default resolution (2^PWM_BITS-1)
//   fade_state_t     : brightness fade FSM states (IDLE, FADE)
package led_pkg;

  localparam int unsigned PWM_BITS_DEFAULT = 8;
  localparam int unsigned LEVEL_MAX        = (1 << PWM_BITS_DEFAULT) - 1;

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } fade_state_t;

endpackage

// File: rtl/pwm_period_counter.sv
// pwm_period_counter: free-running PWM period counter.
// Counts 0 .. 2^WIDTH-2 and wraps to 0, giving a period of 2^WIDTH-1 clocks so
// a compare value of 2^WIDTH-1 yields a constant-on waveform.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (cnt -> 0)
//   cnt   : current position within the period
//   wrap  : high during the last count of the period (period boundary)
module pwm_period_counter
  import led_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_BITS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'((1 << WIDTH) - 2);

  assign wrap = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/led_pwm_dimmer.sv
// led_pwm_dimmer: gates the blinker's LED bus with a shared PWM waveform.
// Brightness target is stepped by single-cycle up/down pulses (saturating);
// the active level fades toward the target one step per PWM period, and only
// changes at a period boundary so no period mixes two duties.
// Optional feature macro: LED_PWM_GAMMA_EN -- compare value is
// (active*active)>>PWM_BITS (full-on kept full-on), registered, so the
// compare lags the active level by one clock.
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   led_in   : blink pattern, same clock domain
//   level_up : single-cycle request, target += STEP
//   level_dn : single-cycle request, target -= STEP
//   led_out  : dimmed LED drive, registered (1-clock latency from led_in)
//   level    : current active level
//   fading   : high while active level differs from target
module led_pwm_dimmer
  import led_pkg::*;
#(
  parameter int unsigned NUM_LEDS      = 4,
  parameter int unsigned PWM_BITS      = PWM_BITS_DEFAULT,
  parameter int unsigned LEVEL_DEFAULT = 128,
  parameter int unsigned STEP          = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_LEDS-1:0] led_in,
  input  logic                level_up,
  input  logic                level_dn,
  output logic [NUM_LEDS-1:0] led_out,
  output logic [PWM_BITS-1:0] level,
  output logic                fading
);

  localparam logic [PWM_BITS-1:0] LVL_MAX = PWM_BITS'((1 << PWM_BITS) - 1);
  localparam logic [PWM_BITS-1:0] LVL_RST = PWM_BITS'(LEVEL_DEFAULT);
  localparam logic [PWM_BITS-1:0] STEP_N  = PWM_BITS'(STEP);
  localparam logic [PWM_BITS:0]   STEP_W  = (PWM_BITS + 1)'(STEP);

  logic [PWM_BITS-1:0] cnt;
  logic                boundary;
  logic [PWM_BITS-1:0] target_q, target_d;
  logic [PWM_BITS-1:0] active_q, active_d;
  logic [PWM_BITS:0]   up_sum;
  logic [PWM_BITS-1:0] cmp;
  logic                pwm_on;
  fade_state_t         state_q, state_d;

  pwm_period_counter #(
    .WIDTH (PWM_BITS)
  ) u_period (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt   (cnt),
    .wrap  (boundary)
  );

  // Target update; the sum is one bit wider so overflow is seen before
  // saturating to full-on.
  always_comb begin
    target_d = target_q;
    up_sum   = {1'b0, target_q} + STEP_W;
    if (level_up && !level_dn) begin
      target_d = (up_sum > {1'b0, LVL_MAX}) ? LVL_MAX : up_sum[PWM_BITS-1:0];
    end else if (level_dn && !level_up) begin
      target_d = ({1'b0, target_q} < STEP_W) ? '0 : (target_q - STEP_N);
    end
  end

  // Fade FSM. Decisions use the next target so a pulse raises fading after
  // one clock and a retarget mid-fade takes effect at the next boundary.
  always_comb begin
    active_d = active_q;
    state_d  = state_q;
    case (state_q)
      IDLE: begin
        if (target_d != active_q) begin
          state_d = FADE;
        end
      end
      FADE: begin
        if (boundary) begin
          if (active_q < target_d) begin
            active_d = active_q + PWM_BITS'(1);
          end else if (active_q > target_d) begin
            active_d = active_q - PWM_BITS'(1);
          end
        end
        if (active_d == target_d) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= LVL_RST;
      active_q <= LVL_RST;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      active_q <= active_d;
    end
  end

`ifdef LED_PWM_GAMMA_EN
  localparam logic [PWM_BITS-1:0] CMP_RST =
    (LVL_RST == LVL_MAX) ? LVL_MAX
                         : PWM_BITS'((LEVEL_DEFAULT * LEVEL_DEFAULT) >> PWM_BITS);

  logic [2*PWM_BITS-1:0] active_sq;

  assign active_sq = (2*PWM_BITS)'(active_q) * (2*PWM_BITS)'(active_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp <= CMP_RST;
    end else if (active_q == LVL_MAX) begin
      cmp <= LVL_MAX;
    end else begin
      cmp <= PWM_BITS'(active_sq >> PWM_BITS);
    end
  end
`else
  assign cmp = active_q;
`endif

  // Level 0 never beats cnt; full-on exceeds the highest count (2^PWM_BITS-2).
  assign pwm_on = (cnt < cmp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_out <= '0;
    end else begin
      led_out <= led_in & {NUM_LEDS{pwm_on}};
    end
  end

  assign level  = active_q;
  assign fading = (state_q == FADE);

endmodule
